// File: rtl/lsu_ram_ctrl_if.sv
// Core-side request/response and RAM-port signals of the load/store sequencer.
// The controller takes the slave view; core and RAM side together take the master view.
interface lsu_ram_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
        input  req_addr_i, req_wdata_i, ram_data_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
        output req_addr_i, req_wdata_i, ram_data_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/lsu_ram_ctrl.sv
// Load/store sequencer: splits word-crossing accesses into two RAM
// transactions, realigns and extends load data, rejects illegal requests.
module lsu_ram_ctrl #(
    parameter int unsigned DATA_DEPTH = 8192
) (
    input logic           clk_i,
    input logic           rst_ni,
    lsu_ram_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP
    } state_t;

    localparam logic [29:0] DEPTH = 30'(DATA_DEPTH);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] w0;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;

    logic        idle;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [3:0]  smask;
    logic [2:0]  nb;
    logic        split;
    logic        err;
    logic [29:0] word0;
    logic [29:0] word1;
    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [63:0] pair;
    logic [31:0] sh;
    logic [31:0] rd;

    function automatic logic [3:0] rev4(input logic [3:0] m);
        return {m[0], m[1], m[2], m[3]};
    endfunction

    // Decode the live request in IDLE, the registered one afterwards.
    always_comb begin
        idle  = (state == S_IDLE);
        a     = idle ? bus.req_addr_i  : addr_q;
        wd    = idle ? bus.req_wdata_i : wdata_q;
        sz    = idle ? bus.req_size_i  : size_q;
        off   = a[1:0];
        word0 = a[31:2];
        word1 = word0 + 30'd1;
        smask = 4'b0000;
        nb    = 3'd4;
        unique case (sz)
            2'b00:   begin smask = 4'b0001; nb = 3'd1; end
            2'b01:   begin smask = 4'b0011; nb = 3'd2; end
            2'b10:   begin smask = 4'b1111; nb = 3'd4; end
            default: begin smask = 4'b0000; nb = 3'd4; end
        endcase
        split = ({1'b0, off} + nb) > 3'd4;
        err   = (sz == 2'b11) || (word0 >= DEPTH)
             || (split && (word1 >= DEPTH));
        mask8 = {4'b0000, smask} << off;
        wide  = {32'b0, wd} << {off, 3'b000};
        pair  = split ? {bus.ram_data_i, w0}
                      : {32'b0, bus.ram_data_i};
        sh    = 32'(pair >> {off, 3'b000});
        rd    = sh;
        unique case (sz)
            2'b00:   rd = {{24{~uns_q & sh[7]}}, sh[7:0]};
            2'b01:   rd = {{16{~uns_q & sh[15]}}, sh[15:0]};
            default: rd = sh;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            w0        <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q  <= bus.req_addr_i;
                        wdata_q <= bus.req_wdata_i;
                        size_q  <= bus.req_size_i;
                        we_q    <= bus.req_we_i;
                        uns_q   <= bus.req_unsigned_i;
                        if (err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= S_ACC0;
                            ram_en   <= 1'b1;
                            ram_we   <= bus.req_we_i ? rev4(mask8[3:0])
                                                     : 4'b0000;
                            ram_addr <= {word0, 2'b00};
                            ram_data <= wide[31:0];
                        end
                    end
                end
                S_ACC0: begin
                    if (split) begin
                        state    <= S_ACC1;
                        ram_we   <= we_q ? rev4(mask8[7:4]) : 4'b0000;
                        ram_addr <= {word1, 2'b00};
                        ram_data <= wide[63:32];
                    end else begin
                        ram_en   <= 1'b0;
                        ram_we   <= '0;
                        ram_addr <= '0;
                        ram_data <= '0;
                        if (we_q) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_ACC1: begin
                    ram_en   <= 1'b0;
                    ram_we   <= '0;
                    ram_addr <= '0;
                    ram_data <= '0;
                    if (we_q) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        w0    <= bus.ram_data_i;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rsp_rdata <= rd;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = idle;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.ram_en_o    = ram_en;
    assign bus.ram_we_o    = ram_we;
    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_data_o  = ram_data;
endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Bench for lsu_ram_ctrl: byte-array RAM, byte-level reference model,
// directed scenarios and randomized requests.
module tb_lsu_ram_ctrl;
    localparam int DEPTH  = 8192;
    localparam int NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ram_ctrl_if bus();

    lsu_ram_ctrl #(.DATA_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    logic [7:0] ram  [NBYTES] = '{default: 8'h00};
    logic [7:0] refm [NBYTES];

    int checks = 0;
    int errors = 0;

    // Synchronous byte-laned RAM: old contents on read-during-write.
    always @(posedge clk) begin
        if (bus.ram_en_o === 1'b1 && bus.ram_addr_o < NBYTES) begin
            int b;
            b = int'(bus.ram_addr_o) & ~3;
            bus.ram_data_i <= {ram[b+3], ram[b+2], ram[b+1], ram[b]};
            for (int k = 0; k < 4; k++)
                if (bus.ram_we_o[3-k])
                    ram[b+k] <= bus.ram_data_o[8*k +: 8];
        end
    end

    int          o_lat;
    int          o_ntx;
    logic        o_err;
    logic [31:0] o_rdata;
    logic [3:0]  tx_we   [2];
    logic [31:0] tx_addr [2];
    logic [31:0] tx_data [2];

    logic        e_err;
    int          e_lat;
    int          e_ntx;
    logic [31:0] e_rd;

    // Byte-level reference: legality, latency, memory update, load value.
    function automatic void model(input logic we, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] a,
                                  input logic [31:0] wd);
        int nb;
        bit sp;
        logic [31:0] b;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e_err = (sz == 2'd3);
        for (int i = 0; i < nb; i++) begin
            b = a + 32'(i);
            if (b >= NBYTES) e_err = 1'b1;
        end
        sp = (int'(a[1:0]) + nb) > 4;
        e_rd = 32'h0;
        if (e_err) begin
            e_lat = 1;
            e_ntx = 0;
            return;
        end
        e_ntx = sp ? 2 : 1;
        e_lat = we ? (sp ? 3 : 2) : (sp ? 4 : 3);
        for (int i = 0; i < nb; i++) begin
            b = a + 32'(i);
            if (we) refm[int'(b)] = wd[8*i +: 8];
            else e_rd = e_rd | (32'(refm[int'(b)]) << (8 * i));
        end
        if (!we && !uns && nb < 4 && e_rd[8*nb-1])
            e_rd = e_rd | (32'hFFFF_FFFF << (8 * nb));
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input bit junk);
        int g;
        g = 0;
        while (bus.req_ready_o !== 1'b1 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got %b required 1", bus.req_ready_o);
        end
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        @(posedge clk); #1;
        o_lat = 0; o_ntx = 0; o_err = 1'b0; o_rdata = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.ram_en_o === 1'b1) begin
                if (o_ntx < 2) begin
                    tx_we[o_ntx]   = bus.ram_we_o;
                    tx_addr[o_ntx] = bus.ram_addr_o;
                    tx_data[o_ntx] = bus.ram_data_o;
                end
                o_ntx++;
            end
            if (bus.rsp_valid_o === 1'b1) begin
                o_lat   = c;
                o_err   = bus.rsp_err_o;
                o_rdata = bus.rsp_rdata_o;
                break;
            end
            bus.req_valid_i = junk;
            if (junk) begin
                bus.req_we_i       = 1'($urandom);
                bus.req_size_i     = 2'($urandom);
                bus.req_unsigned_i = 1'($urandom);
                bus.req_addr_i     = $urandom;
                bus.req_wdata_i    = $urandom;
            end
            @(posedge clk); #1;
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        if (bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b required 1", bus.req_ready_o);
        end
        checks++;
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_rsp got %b%b required 00", bus.rsp_valid_o, bus.rsp_err_o);
        end
        checks++;
        if (bus.rsp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL rst_rdata got %h required 0", bus.rsp_rdata_o);
        end
        checks++;
        if ({bus.ram_en_o, bus.ram_we_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_ram_en_we got %b %b required 0 0000", bus.ram_en_o, bus.ram_we_o);
        end
        checks++;
        if ({bus.ram_addr_o, bus.ram_data_o} !== 64'h0) begin
            errors++;
            $display("FAIL rst_ram_bus got %h %h required 0 0", bus.ram_addr_o, bus.ram_data_o);
        end
    endtask

    task automatic test_aligned_word();
        model(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
        checks++;
        if (o_lat !== 2 || o_err !== 1'b0) begin
            errors++; $display("FAIL aw_store_rsp got lat %0d err %b required lat 2 err 0", o_lat, o_err);
        end
        checks++;
        if (o_ntx !== 1 || tx_we[0] !== 4'b1111 || tx_addr[0] !== 32'h100) begin
            errors++;
            $display("FAIL aw_store_tx got n %0d we %b addr %h required 1 1111 100", o_ntx, tx_we[0], tx_addr[0]);
        end
        model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0);
        checks++;
        if (o_lat !== 3 || o_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL aw_load got lat %0d data %h required lat 3 data deadbeef", o_lat, o_rdata);
        end
    endtask

    task automatic test_byte();
        model(1'b1, 2'd0, 1'b0, 32'h103, 32'h80);
        do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h80, 1'b0);
        checks++;
        if (tx_we[0] !== 4'b0001 || tx_data[0][31:24] !== 8'h80) begin
            errors++;
            $display("FAIL byte_store got we %b data %h required 0001 80xxxxxx", tx_we[0], tx_data[0]);
        end
        model(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b0);
        checks++;
        if (o_rdata !== 32'hFFFFFF80) begin
            errors++; $display("FAIL byte_load_s got %h required ffffff80", o_rdata);
        end
        model(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b0);
        checks++;
        if (o_rdata !== 32'h00000080) begin
            errors++; $display("FAIL byte_load_u got %h required 00000080", o_rdata);
        end
    endtask

    task automatic test_misaligned();
        model(1'b1, 2'd2, 1'b0, 32'h202, 32'h11223344);
        do_req(1'b1, 2'd2, 1'b0, 32'h202, 32'h11223344, 1'b0);
        checks++;
        if (o_ntx !== 2 || o_lat !== 3) begin
            errors++; $display("FAIL mis_store got n %0d lat %0d required 2 3", o_ntx, o_lat);
        end
        checks++;
        if (tx_addr[0] !== 32'h200 || tx_we[0] !== 4'b0011 || tx_data[0][31:16] !== 16'h3344) begin
            errors++;
            $display("FAIL mis_tx0 got %h %b %h required 200 0011 3344xxxx", tx_addr[0], tx_we[0], tx_data[0]);
        end
        checks++;
        if (tx_addr[1] !== 32'h204 || tx_we[1] !== 4'b1100 || tx_data[1][15:0] !== 16'h1122) begin
            errors++;
            $display("FAIL mis_tx1 got %h %b %h required 204 1100 xxxx1122", tx_addr[1], tx_we[1], tx_data[1]);
        end
        model(1'b0, 2'd2, 1'b0, 32'h202, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h202, 32'h0, 1'b0);
        checks++;
        if (o_lat !== 4 || o_rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL mis_load got lat %0d data %h required 4 11223344", o_lat, o_rdata);
        end
    endtask

    task automatic test_split_half();
        model(1'b1, 2'd0, 1'b0, 32'h1FF, 32'hAB);
        do_req(1'b1, 2'd0, 1'b0, 32'h1FF, 32'hAB, 1'b0);
        model(1'b1, 2'd0, 1'b0, 32'h200, 32'h9C);
        do_req(1'b1, 2'd0, 1'b0, 32'h200, 32'h9C, 1'b0);
        model(1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0, 1'b0);
        checks++;
        if (o_ntx !== 2 || o_rdata !== 32'hFFFF9CAB) begin
            errors++;
            $display("FAIL split_half got n %0d data %h required 2 ffff9cab", o_ntx, o_rdata);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz = '{2'd3, 2'd2, 2'd2};
        ad = '{32'h40, 32'h8000, 32'h7FFE};
        for (int i = 0; i < 3; i++) begin
            model(i == 2, sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
            do_req(i == 2, sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, 1'b0);
            checks++;
            if (o_lat !== 1 || o_err !== 1'b1 || o_ntx !== 0 || o_rdata !== 32'h0) begin
                errors++;
                $display("FAIL err_%0d got lat %0d err %b ntx %0d data %h required 1 1 0 0",
                         i, o_lat, o_err, o_ntx, o_rdata);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b1;
        bus.req_size_i     = 2'd2;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h302;
        bus.req_wdata_i    = 32'hA1B2C3D4;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ram_en_o !== 1'b1 || bus.ram_addr_o !== 32'h304) begin
            errors++;
            $display("FAIL mid_acc1 got en %b addr %h required 1 304", bus.ram_en_o, bus.ram_addr_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.ram_en_o,
             bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o} !== 103'h0
            || bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_outputs got en %b we %b addr %h rdy %b required 0 0 0 1",
                     bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o, bus.req_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_after got rsp_seen %b rdy %b required 0 1", seen, bus.req_ready_o);
        end
        refm[32'h302] = 8'hD4;
        refm[32'h303] = 8'hC3;
        model(1'b0, 2'd1, 1'b1, 32'h302, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h302, 32'h0, 1'b0);
        checks++;
        if (o_rdata !== e_rd || e_rd !== 32'h0000C3D4) begin
            errors++; $display("FAIL mid_first_word got %h required 0000c3d4", o_rdata);
        end
        model(1'b0, 2'd2, 1'b1, 32'h304, 32'h0);
        do_req(1'b0, 2'd2, 1'b1, 32'h304, 32'h0, 1'b0);
        checks++;
        if (o_rdata !== e_rd) begin
            errors++; $display("FAIL mid_second_word got %h required %h", o_rdata, e_rd);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic        uns;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        int          r;
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom);
            uns = 1'($urandom);
            wd  = $urandom;
            r   = $urandom_range(0, 15);
            sz  = (r == 0) ? 2'd3 : 2'(r % 3);
            r   = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, 255));
            else if (r < 8) a = 32'h7FF0 + 32'($urandom_range(0, 19));
            else if (r < 9) a = 32'($urandom_range(0, NBYTES - 1));
            else            a = $urandom;
            model(we, sz, uns, a, wd);
            do_req(we, sz, uns, a, wd, 1'b1);
            checks++;
            if (o_err !== e_err || o_lat !== e_lat || o_ntx !== e_ntx) begin
                errors++;
                $display("FAIL rnd_ctl a=%h sz=%0d we=%b got err %b lat %0d n %0d required %b %0d %0d",
                         a, sz, we, o_err, o_lat, o_ntx, e_err, e_lat, e_ntx);
            end
            checks++;
            if (o_rdata !== e_rd) begin
                errors++;
                $display("FAIL rnd_data a=%h sz=%0d u=%b we=%b got %h required %h",
                         a, sz, uns, we, o_rdata, e_rd);
            end
            if (e_ntx > 0) begin
                checks++;
                if (tx_addr[0] !== {a[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rnd_addr got %h required %h", tx_addr[0], {a[31:2], 2'b00});
                end
            end
            @(posedge clk); #1;
            checks++;
            if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rnd_b2b got rdy %b rsp %b required 1 0",
                         bus.req_ready_o, bus.rsp_valid_o);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) refm[i] = 8'h00;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h0;
        bus.req_wdata_i    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_aligned_word();
        test_byte();
        test_misaligned();
        test_split_half();
        test_errors();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ram_ctrl.md
# lsu_ram_ctrl

Load/store sequencer placed between the core's memory stage and one port of the byte-laned data RAM. It accepts one byte, halfword or word request at a time and translates it into RAM transactions. Each transaction has a word address, per-lane write enables and lane-shifted write data. Word-crossing (misaligned) accesses are split into two transactions. Read data is realigned and sign- or zero-extended, and a single-cycle response is returned. Out-of-range or illegal-size requests are rejected without touching the RAM.

## Interface
Parameters:
- DATA_DEPTH, 8192, words in the attached RAM; valid byte addresses are 0 .. 4*DATA_DEPTH-1

Ports:
- clk_i  in  1  clock; RAM port clocked from the same net
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0
- req_addr_i  in  32  byte address, any alignment
- req_wdata_i  in  32  store data, LSB-aligned (byte i at bits 8i+7:8i)
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_err_o  out  1  qualifies rsp_valid_o; request rejected
- rsp_rdata_o  out  32  load result; 0 for stores and errors
- ram_en_o  out  1  RAM port enable
- ram_we_o  out  4  lane write enables; we[3-k] writes byte offset k
- ram_addr_o  out  32  byte address, bits 1:0 always 0 (the RAM indexes by addr>>2)
- ram_data_o  out  32  write data; byte offset k on bits 8k+7:8k
- ram_data_i  in  32  read data, valid the cycle after ram_en_o (old contents on a write)

## Operation
- Handshake: req_ready_o = 1 only in IDLE. On acceptance, the controller registers addr, size, we, unsigned and wdata. Inputs are ignored outside IDLE.
- Decode:
  - off = addr[1:0]; nbytes = 1/2/4.
  - split = (off + nbytes > 4).
  - word0 = addr[31:2]; word1 = word0 + 1 (30-bit, wraps).
- Error: size 11, word0 >= DATA_DEPTH, or split with word1 >= DATA_DEPTH. The controller goes to RESP with rsp_err_o = 1 and issues no RAM access, so no partial write occurs.
- Lane math:
  - mask8 = {4'b0, sizemask} << off, with sizemask 0001/0011/1111.
  - wide = {32'b0, wdata} << 8*off.
  - Transaction 0 uses mask8[3:0] and wide[31:0]. Transaction 1 uses mask8[7:4] and wide[63:32].
  - ram_we_o = bit-reversed lane mask for stores, 0000 for loads.
- Load realign: rd = ({w1, w0} >> 8*off) truncated to nbytes, then extended per req_unsigned_i. Halfword sign bit = bit 15, byte sign bit = bit 7.
- FSM states: IDLE, ACC0, ACC1, WAIT, RESP.
  - IDLE → ACC0 on handshake, or → RESP if error.
  - ACC0 drives transaction 0. Next state: ACC1 if split; else WAIT for a load; else RESP.
  - ACC1 drives transaction 1 and, for a load, captures ram_data_i into w0. Next: WAIT for a load, RESP for a store.
  - WAIT captures ram_data_i into the last slot (w1 if split, else w0) and computes rd. Next: RESP.
  - RESP asserts rsp_valid_o for one cycle. Next: IDLE.
- RAM outputs are registered. They are 0 in every state except ACC0/ACC1.

## Timing
- Reset values: req_ready_o = 1 (IDLE). rsp_valid_o, rsp_err_o, rsp_rdata_o, ram_en_o, ram_we_o, ram_addr_o and ram_data_o are all 0.
- Handshake in cycle 0; rsp_valid_o appears in:
  - cycle 1 for an error
  - cycle 2 for an aligned store
  - cycle 3 for an aligned load or split store
  - cycle 4 for a split load
- req_ready_o returns in the cycle after RESP, so the request-to-next-accept distance is latency+1.
- No response back-pressure: the requester must accept rsp_valid_o when it is pulsed.
- Reset mid-operation: the state returns to IDLE immediately and all outputs go to their reset values. A RAM write already clocked in remains. No response is emitted for the aborted request.
- Address wrap: word1 is computed modulo 2^30. Any wrap beyond DATA_DEPTH is caught by the range check.

## Test plan
- Aligned word store, then load, at 0x100 with data 0xDEADBEEF:
  - store: ram_we_o = 1111, ram_addr_o = 0x100; rsp in cycle 2 with err 0.
  - load: rsp in cycle 3 with rsp_rdata_o = 0xDEADBEEF.
- Byte store 0x80 to 0x103, then load back:
  - store: ram_we_o = 0001, ram_data_o[31:24] = 0x80.
  - signed byte load returns 0xFFFFFF80; unsigned byte load returns 0x00000080.
- Misaligned word store 0x11223344 at 0x202, followed by a word load at 0x202:
  - store transaction 0: addr 0x200, we 0011, data[31:16] = 0x3344.
  - store transaction 1: addr 0x204, we 1100, data[15:0] = 0x1122.
  - load: rsp in cycle 4 with data 0x11223344.
- Halfword load at 0x1FF after storing bytes 0xAB at 0x1FF and 0x9C at 0x200:
  - split into two transactions; signed result 0xFFFF9CAB.
- Error cases, each giving rsp_err_o = 1 in cycle 1, with ram_en_o never asserted:
  - size 11
  - address 0x8000 with DATA_DEPTH = 8192
  - word access at 0x7FFE (split, second word out of range)
- Deassert rst_ni during ACC1 of a split store:
  - outputs drop to reset values asynchronously.
  - req_ready_o = 1 after release.
  - no rsp_valid_o is emitted.
  - the first-word bytes remain written.
